// File: rtl/bus_arbiter.sv
// Two-port (fetch I / data D) arbiter onto one shared memory port, one transaction outstanding; accept is same-cycle, m_* one cycle later.
// Backpressure: requesters hold valid until accept; D wins ties unless I has been passed over STARVE_LIMIT times in a row.
module bus_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_valid,
    input  logic [31:0] i_addr,
    output logic        i_accept,
    output logic        i_done,
    output logic [31:0] i_rdata,
    input  logic        d_valid,
    input  logic [31:0] d_addr,
    input  logic        d_write,
    input  logic [3:0]  d_strobe,
    input  logic [31:0] d_wdata,
    output logic        d_accept,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        m_valid,
    output logic [31:0] m_addr,
    output logic        m_write,
    output logic [3:0]  m_strobe,
    output logic [31:0] m_wdata,
    input  logic        m_ok,
    input  logic [31:0] m_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t      state;
    logic [2:0]  starve_cnt;
    logic [31:0] addr_q;
    logic        write_q;
    logic [3:0]  strobe_q;
    logic [31:0] wdata_q;

    logic busy;
    logic free;
    logic i_starved;
    logic grant_d;
    logic grant_i;

    // A completing transaction frees the port in the same cycle so the next grant has no bubble.
    assign busy      = (state != IDLE);
    assign free      = !busy || m_ok;
    assign i_starved = i_valid && (int'(starve_cnt) == STARVE_LIMIT);
    assign grant_d   = !reset && free && d_valid && !i_starved;
    assign grant_i   = !reset && free && i_valid && !grant_d;

    assign i_accept = grant_i;
    assign d_accept = grant_d;
    assign i_done   = !reset && (state == BUSY_I) && m_ok;
    assign d_done   = !reset && (state == BUSY_D) && m_ok;
    assign i_rdata  = i_done ? m_rdata : 32'h0;
    assign d_rdata  = d_done ? m_rdata : 32'h0;

    assign m_valid  = busy;
    assign m_addr   = busy ? addr_q   : 32'h0;
    assign m_write  = busy ? write_q  : 1'b0;
    assign m_strobe = busy ? strobe_q : 4'h0;
    assign m_wdata  = busy ? wdata_q  : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= 3'd0;
            addr_q     <= 32'h0;
            write_q    <= 1'b0;
            strobe_q   <= 4'h0;
            wdata_q    <= 32'h0;
        end else if (grant_d) begin
            state    <= BUSY_D;
            addr_q   <= d_addr;
            write_q  <= d_write;
            strobe_q <= d_strobe;
            wdata_q  <= d_wdata;
            // Only a D grant that actually overtakes a waiting I counts toward starvation.
            if (i_valid)
                starve_cnt <= (starve_cnt == 3'd7) ? starve_cnt : starve_cnt + 3'd1;
            else
                starve_cnt <= 3'd0;
        end else if (grant_i) begin
            state      <= BUSY_I;
            addr_q     <= i_addr;
            write_q    <= 1'b0;
            strobe_q   <= 4'h0;
            wdata_q    <= 32'h0;
            starve_cnt <= 3'd0;
        end else if (busy && m_ok) begin
            state    <= IDLE;
            addr_q   <= 32'h0;
            write_q  <= 1'b0;
            strobe_q <= 4'h0;
            wdata_q  <= 32'h0;
        end
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: max consecutive D grants while I is pending.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port i_valid  input  1  fetch read request; held high until i_accept.
REQ-005 SHALL have port i_addr  input  32  fetch address.
REQ-006 SHALL have port i_accept  output  1  one-cycle pulse: I request latched.
REQ-007 SHALL have port i_done  output  1  one-cycle pulse: I read data valid.
REQ-008 SHALL have port i_rdata  output  32  I read data, valid when i_done.
REQ-009 SHALL have port d_valid  input  1  data request; held high until d_accept.
REQ-010 SHALL have port d_addr  input  32  data address.
REQ-011 SHALL have port d_write, d_strobe, d_wdata  input  1/4/32  write flag, byte enables, write data.
REQ-012 SHALL have port d_accept, d_done  output  1  same meaning as the I pair.
REQ-013 SHALL have port d_rdata  output  32  D read data, valid when d_done and !write.
REQ-014 SHALL have port m_valid  output  1  shared-memory request active.
REQ-015 SHALL have port m_addr, m_write, m_strobe, m_wdata  output  32/1/4/32  latched request fields.
REQ-016 SHALL have port m_ok  input  1  memory completion pulse; m_rdata valid this cycle.
REQ-017 SHALL have port m_rdata  input  32  memory read data.

Function
REQ-018 SHALL implement FSM states IDLE, BUSY_I, BUSY_D; exactly one transaction outstanding.
REQ-019 SHALL arbitrate in IDLE, or in BUSY_* during the cycle m_ok=1 (back-to-back, no idle bubble).
REQ-020 SHALL grant D over I when both are valid, unless starve_cnt == STARVE_LIMIT, then grant I.
REQ-021 SHALL keep starve_cnt (3-bit saturating): +1 on a D grant with i_valid high; cleared on any I grant or when i_valid is low at a D grant.
REQ-022 On grant SHALL pulse the winner's *_accept combinationally in that cycle and latch its addr/write/strobe/wdata on the edge; I grants latch write=0, strobe=0, wdata=0.
REQ-023 SHALL drive m_valid=1 and m_* from latched registers only in BUSY_I/BUSY_D; m_valid=0 and m_* = 0 in IDLE.
REQ-024 SHALL hold m_* constant throughout a BUSY state until m_ok.
REQ-025 On m_ok in BUSY_I SHALL pulse i_done with i_rdata=m_rdata that cycle; same for BUSY_D with d_done/d_rdata.
REQ-026 SHALL set *_rdata to 0 whenever the matching *_done is 0.
REQ-027 On m_ok with no pending valid SHALL go to IDLE; with a pending valid SHALL go directly to the new BUSY state.
REQ-028 SHALL ignore m_ok while in IDLE (no done pulse, no state change).
REQ-029 SHALL never assert i_accept and d_accept in the same cycle, nor either *_accept while BUSY without m_ok.
REQ-030 A requester dropping valid before accept SHALL simply not be granted; no error state.
REQ-031 Minimum latency: valid in cycle N -> accept in N (if free) -> m_valid in N+1 -> done in the m_ok cycle (>= N+1).

Reset
REQ-032 While reset=1 at a clock edge, SHALL go to IDLE, clear starve_cnt and all latched request registers.
REQ-033 After reset, all outputs SHALL be 0 until new requests arrive.
REQ-034 Reset mid-transaction SHALL abandon it: m_valid=0 the next cycle, no *_done for it, any later m_ok ignored.
REQ-035 During the reset cycle, *_accept SHALL be 0 regardless of valids.

Verification
REQ-036 Single I: i_valid=1, i_addr=0xbfc00000, m_ok 2 cycles after m_valid, m_rdata=0x24020001 -> i_accept cycle 0, m_addr=0xbfc00000 cycle 1, i_done and i_rdata=0x24020001 cycle 3.
REQ-037 Simultaneous: i_valid=d_valid=1, d_addr=0x80000010 write, strobe=0xF -> D granted first with m_write=1; I granted in D's m_ok cycle, m_addr switches to I address next cycle without IDLE.
REQ-038 Starvation: i_valid held, d_valid held for 6 requests, m_ok each 1 cycle -> 4 D grants, then I, then D.
REQ-039 Reset at BUSY_D, then m_ok=1 -> no d_done, m_valid=0, state IDLE, starve_cnt=0.
REQ-040 Spurious m_ok=1 in IDLE with no valids -> all outputs stay 0.
